// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Op encoding, FSM states and default operand width.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/full_subtractor1bit.sv
// One-bit full subtractor cell: diff = a - b - b_in.
// Ports: i_a, i_b, i_b_in (borrow in), o_diff, o_b_out (borrow out).
module full_subtractor1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_b_in,
  output logic o_diff,
  output logic o_b_out
);

  assign o_diff  = i_a ^ i_b ^ i_b_in;
  assign o_b_out = (~i_a & i_b) | (~(i_a ^ i_b) & i_b_in);

endmodule

// File: rtl/divider_iterative.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Ports: i_clk, i_reset, i_start/i_op/i_dividend/i_divisor in; o_ready, o_valid, o_result out.
module divider_iterative
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             vld_q, vld_d;

  // Trial subtraction is WIDTH+1 wide: the shifted partial
  // remainder can exceed 2^WIDTH-1 for large unsigned divisors.
  logic [WIDTH:0]   ta, tb, tdiff;
  logic [WIDTH+1:0] brw;
  logic             borrow;

  assign ta     = {rem_q, quo_q[WIDTH-1]};
  assign tb     = {1'b0, dvs_q};
  assign brw[0] = 1'b0;
  assign borrow = brw[WIDTH+1];

  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
    full_subtractor1bit u_fs (
      .i_a    (ta[gi]),
      .i_b    (tb[gi]),
      .i_b_in (brw[gi]),
      .o_diff (tdiff[gi]),
      .o_b_out(brw[gi+1])
    );
  end

  logic             is_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fin_rem, fin_quo;

  assign is_sgn = ~i_op[0];
  assign a_neg  = is_sgn & i_dividend[WIDTH-1];
  assign b_neg  = is_sgn & i_divisor[WIDTH-1];
  assign a_mag  = a_neg ? -i_dividend : i_dividend;
  assign b_mag  = b_neg ? -i_divisor : i_divisor;

  assign step_rem = borrow ? ta[WIDTH-1:0] : tdiff[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], ~borrow};
  assign fin_rem  = negr_q ? -step_rem : step_rem;
  assign fin_quo  = negq_q ? -step_quo : step_quo;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    vld_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          op_d   = op_e'(i_op);
          rem_d  = '0;
          quo_d  = a_mag;
          dvs_d  = b_mag;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          cnt_d  = '0;
          if (i_divisor == '0) begin
            state_d = S_DONE;
            vld_d   = 1'b1;
            res_d   = i_op[1] ? i_dividend : '1;
          end else if (is_sgn && i_dividend == MIN_NEG
                       && i_divisor == '1) begin
            state_d = S_DONE;
            vld_d   = 1'b1;
            res_d   = i_op[1] ? '0 : MIN_NEG;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = S_DONE;
          vld_d   = 1'b1;
          res_d   = op_q[1] ? fin_rem : fin_quo;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_DIV;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      vld_q   <= vld_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = vld_q;
  assign o_result = res_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Scoreboard bench for divider_iterative: directed + random ops
// against a plain-arithmetic reference model.
module tb_divider_iterative;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;

  divider_iterative #(.WIDTH(32)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_dividend(i_dividend),
    .i_divisor (i_divisor),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_result  (o_result)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(logic [1:0] op,
                                          logic [31:0] a,
                                          logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00: return $signed(a) / $signed(b);
      2'b01: return a / b;
      2'b10: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(logic [1:0] op,
                                 logic [31:0] a,
                                 logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Monitor: pops one expectation per valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got %h want none",
                   o_result);
        end else begin
          e = sb.pop_front();
          chk("result", o_result, e.res);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("ready_in_done", {31'b0, o_ready}, 32'h0);
        end
      end
    end
  end

  task automatic issue(logic [1:0] op, logic [31:0] a,
                       logic [31:0] b);
    exp_t e;
    int n = 0;
    @(negedge i_clk);
    while (!o_ready) begin
      @(negedge i_clk);
      n++;
      if (n > 200) begin
        chk("ready_timeout", 32'h0, 32'h1);
        return;
      end
    end
    i_start    = 1'b1;
    i_op       = op;
    i_dividend = a;
    i_divisor  = b;
    e.res = ref_res(op, a, b);
    e.lat = ref_lat(op, a, b);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  logic [31:0] ra, rb;
  logic [1:0]  rop;

  initial begin
    #1;
    chk("rst_ready", {31'b0, o_ready}, 32'h1);
    chk("rst_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_result", o_result, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;

    issue(2'b01, 100, 7);
    issue(2'b11, 100, 7);
    issue(2'b00, 32'hFFFF_FFF9, 2);
    issue(2'b10, 32'hFFFF_FFF9, 2);
    issue(2'b00, 5, 0);
    issue(2'b10, 5, 0);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    issue(2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
    drain();

    // Start pulses while busy must be ignored.
    issue(2'b01, 1000, 7);
    repeat (4) @(negedge i_clk);
    i_start    = 1'b1;
    i_op       = 2'b11;
    i_dividend = 12345;
    i_divisor  = 10;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("ready_busy", {31'b0, o_ready}, 32'h0);
    end
    i_start = 1'b0;
    drain();

    // Reset mid-operation at step 10.
    issue(2'b01, 32'hDEAD_BEEF, 3);
    repeat (9) @(posedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_ready", {31'b0, o_ready}, 32'h1);
    chk("arst_valid", {31'b0, o_valid}, 32'h0);
    chk("arst_result", o_result, 32'h0);
    sb.delete();
    @(negedge i_clk);
    i_reset = 1'b0;
    issue(2'b01, 100, 7);
    drain();

    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(rop, ra, rb);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
